chrom_loader: RTL and testbench
===============================

Name: chrom_loader

Overview:
Serial chromosome assembler. It is the writer side of the phenotype decoder's chromosome bus.
- Accepts a valid/ready stream of 16-bit words: ROW*COL cell truth tables, then OUT output-selector words.
- Packs them into the exact flat chromosome layout the phenotype decoder slices.
- Presents the packed chromosome atomically through a shadow/commit double buffer, so the genetic circuit never sees a partially loaded individual.

Parameters:
- ROW, 4, grid rows (shared package value).
- COL, 4, grid columns (shared package value).
- OUT, 2, number of circuit outputs.
- BITS_ELEM, 5, width of one output-selector field.
- BITS_MAT, ROW*COL*16, derived; truth-table region width.
- CHROM_W, BITS_MAT+BITS_ELEM*OUT, derived; total chromosome width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  16  stream word.
- abort  in  1  synchronous restart of the current load.
- cromossomo  out  CHROM_W  committed chromosome, feeds the phenotype decoder.
- chrom_valid  out  1  one-cycle pulse when cromossomo is updated.
- busy  out  1  high once at least one word of the current load is accepted.
- err  out  1  sticky; only present when the optional feature is enabled.

Behaviour:
- Reset values: cromossomo=0, shadow=0, chrom_valid=0, busy=0, err=0, state=LOAD_MAT, counters=0. Reset is async assert, sync-safe deassert.
- Handshake: a word is accepted on a cycle with s_valid && s_ready. s_ready=1 in LOAD_MAT and LOAD_OUT, 0 in COMMIT. s_data is ignored when not accepted.
- LOAD_MAT:
  - cell counter c runs 0..ROW*COL-1; c=COL*i+j for cell (i,j).
  - Accepted word is written to shadow[16*c+15 -: 16].
  - On accepting c=ROW*COL-1: go to LOAD_OUT, k=0.
- LOAD_OUT:
  - Accepted word's s_data[BITS_ELEM-1:0] is written to shadow[BITS_MAT+BITS_ELEM*(k+1)-1 -: BITS_ELEM]; upper bits are ignored.
  - On accepting k=OUT-1: go to COMMIT.
- COMMIT (one cycle): cromossomo<=shadow, chrom_valid=1, counters clear, busy clears, next state LOAD_MAT.
- Latency: last word accepted at edge N; cromossomo visible and chrom_valid high in the cycle after edge N+1. Minimum load is ROW*COL+OUT+1 cycles.
- cromossomo is stable between commits regardless of stream activity.
- abort: in any state, at the next edge counters clear, state goes to LOAD_MAT, busy clears, shadow is not cleared, cromossomo is unchanged.
  - abort with an accepted word in the same cycle: abort wins and the word is discarded.
  - abort in COMMIT: the commit still completes this cycle and chrom_valid still pulses.
- Reset mid-load: everything returns to reset values, including cromossomo=0.
- No wrap: the counters never exceed their bounds; the state change occurs on the final index.

Optional Feature:
CHROM_LOADER_SEL_CHECK_EN
- Defined:
  - In LOAD_OUT, an accepted word with any nonzero bit in s_data[15:BITS_ELEM] sets err (sticky, cleared only by rst_n).
  - The current load is discarded with abort semantics, so cromossomo is unchanged.
  - The err port exists.
- Undefined: upper bits are silently ignored, there is no err port, and no discard occurs.

Decomposition:
- Shared package:
  - ROW, COL, OUT, BITS_ELEM, BITS_MAT, CHROM_W.
  - Loader state enum (LOAD_MAT, LOAD_OUT, COMMIT).
  - Helper functions cell_lsb(c)=16*c and sel_lsb(k)=BITS_MAT+BITS_ELEM*k, reused by the decoder and benches.
- One natural sub-module: chrom_shadow_reg. It holds the shadow register with per-field write enables and the commit copy.

Test Plan:
- Full load, ROW=COL=2, OUT=1, BITS_ELEM=3:
  - Stimulus: words 0x1111, 0x2222, 0x3333, 0x4444, 0x0005 back-to-back.
  - Required: cromossomo = {3'b101, 0x4444, 0x3333, 0x2222, 0x1111}; chrom_valid pulses exactly once, one cycle after the last accept.
- Backpressure/gaps: s_valid toggled randomly over the same load.
  - Required: identical cromossomo; s_ready=0 only in the COMMIT cycle; a word offered during COMMIT is accepted in the next cycle as cell 0.
- Abort after 2 of 5 words, then a full reload with 0xAAAA…:
  - Required: no chrom_valid and cromossomo unchanged at the abort; the reload commits the new values only.
- abort coincident with accept of the final word:
  - Required: no commit, state LOAD_MAT, cromossomo unchanged.
- rst_n asserted asynchronously mid-LOAD_OUT:
  - Required: cromossomo=0, busy=0, chrom_valid=0 immediately, before any clock edge.
- With CHROM_LOADER_SEL_CHECK_EN: selector word 0x0085 (bit 7 set):
  - Required: err=1 and cromossomo unchanged.
  - Next clean load commits normally; err stays 1.

Source files
------------

// File: rtl/chrom_loader_pkg.sv
// Shared chromosome geometry, loader state encoding and field-offset helpers.
// Used by the loader, the phenotype decoder and the benches.
package chrom_loader_pkg;

  localparam int unsigned ROW       = 4;
  localparam int unsigned COL       = 4;
  localparam int unsigned OUT       = 2;
  localparam int unsigned BITS_ELEM = 5;
  localparam int unsigned BITS_MAT  = ROW * COL * 16;
  localparam int unsigned CHROM_W   = BITS_MAT + BITS_ELEM * OUT;

  typedef enum logic [1:0] {
    StLoadMat = 2'd0,
    StLoadOut = 2'd1,
    StCommit  = 2'd2
  } loader_state_e;

  function automatic int unsigned cell_lsb(input int unsigned c);
    return 16 * c;
  endfunction

  // Geometry arguments default to the package values; parameterised users pass their own.
  function automatic int unsigned sel_lsb(input int unsigned k,
                                          input int unsigned bits_mat  = BITS_MAT,
                                          input int unsigned bits_elem = BITS_ELEM);
    return bits_mat + bits_elem * k;
  endfunction

endpackage

// File: rtl/chrom_loader_if.sv
// Valid/ready word stream feeding the chromosome loader.
interface chrom_loader_if;

  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/chrom_shadow_reg.sv
// Shadow chromosome with per-field write enables and an atomic copy into the
// committed register.
module chrom_shadow_reg
  import chrom_loader_pkg::*;
#(
  parameter int unsigned NumCells = ROW * COL,
  parameter int unsigned Out      = OUT,
  parameter int unsigned BitsElem = BITS_ELEM,
  parameter int unsigned CntW     = 5,
  parameter int unsigned ChromW   = NumCells * 16 + BitsElem * Out
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mat_we,
  input  logic              i_sel_we,
  input  logic [CntW-1:0]   i_idx,
  input  logic [15:0]       i_data,
  input  logic              i_commit,
  output logic [ChromW-1:0] o_chrom
);

  localparam int unsigned BitsMat = NumCells * 16;

  logic [ChromW-1:0] r_shadow;
  logic [ChromW-1:0] r_chrom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int unsigned c = 0; c < NumCells; c++) begin
        if (i_mat_we && (i_idx == CntW'(c))) begin
          r_shadow[cell_lsb(c) +: 16] <= i_data;
        end
      end
      for (int unsigned k = 0; k < Out; k++) begin
        if (i_sel_we && (i_idx == CntW'(k))) begin
          r_shadow[sel_lsb(k, BitsMat, BitsElem) +: BitsElem] <= i_data[BitsElem-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chrom <= '0;
    end else if (i_commit) begin
      r_chrom <= r_shadow;
    end
  end

  assign o_chrom = r_chrom;

endmodule

// File: rtl/chrom_loader.sv
// Serial chromosome assembler: truth-table words, then selector words, committed atomically.
// Optional selector range check with sticky err: define CHROM_LOADER_SEL_CHECK_EN.
module chrom_loader
  import chrom_loader_pkg::*;
#(
  parameter int unsigned Row      = ROW,
  parameter int unsigned Col      = COL,
  parameter int unsigned Out      = OUT,
  parameter int unsigned BitsElem = BITS_ELEM,
  parameter int unsigned ChromW   = Row * Col * 16 + BitsElem * Out
) (
  input  logic              clk,
  input  logic              rst_n,
  chrom_loader_if.slave     s_if,
  input  logic              i_abort,
  output logic [ChromW-1:0] o_cromossomo,
  output logic              o_chrom_valid,
  output logic              o_busy
`ifdef CHROM_LOADER_SEL_CHECK_EN
  ,
  output logic              o_err
`endif
);

  localparam int unsigned NumCells = Row * Col;
  localparam int unsigned CntW     = $clog2(NumCells + Out + 1);
  localparam logic [CntW-1:0] LastCell = CntW'(NumCells - 1);
  localparam logic [CntW-1:0] LastSel  = CntW'(Out - 1);

  loader_state_e   r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic            r_valid;

  logic w_accept;
  logic w_sel_bad;
  logic w_mat_we;
  logic w_sel_we;
  logic w_commit;

  assign s_if.s_ready = (r_state != StCommit);
  assign w_accept     = s_if.s_valid && s_if.s_ready;

`ifdef CHROM_LOADER_SEL_CHECK_EN
  logic r_err;
  assign w_sel_bad = w_accept && (r_state == StLoadOut) && (|s_if.s_data[15:BitsElem]);
  assign o_err     = r_err;
`else
  assign w_sel_bad = 1'b0;
`endif

  // An abort in the same cycle discards the word before it reaches the shadow.
  assign w_mat_we = w_accept && !i_abort && (r_state == StLoadMat);
  assign w_sel_we = w_accept && !i_abort && !w_sel_bad && (r_state == StLoadOut);
  assign w_commit = (r_state == StCommit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StLoadMat;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef CHROM_LOADER_SEL_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef CHROM_LOADER_SEL_CHECK_EN
      if (w_sel_bad && !i_abort) begin
        r_err <= 1'b1;
      end
`endif
      unique case (r_state)
        StLoadMat: begin
          if (i_abort) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end else if (w_accept) begin
            r_busy <= 1'b1;
            if (r_cnt == LastCell) begin
              r_cnt   <= '0;
              r_state <= StLoadOut;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StLoadOut: begin
          if (i_abort || w_sel_bad) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= StLoadMat;
          end else if (w_accept) begin
            if (r_cnt == LastSel) begin
              r_cnt   <= '0;
              r_state <= StCommit;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StCommit: begin
          // Commit completes even if abort is raised here.
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= StLoadMat;
        end
        default: r_state <= StLoadMat;
      endcase
    end
  end

  chrom_shadow_reg #(
    .NumCells (NumCells),
    .Out      (Out),
    .BitsElem (BitsElem),
    .CntW     (CntW),
    .ChromW   (ChromW)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_mat_we (w_mat_we),
    .i_sel_we (w_sel_we),
    .i_idx    (r_cnt),
    .i_data   (s_if.s_data),
    .i_commit (w_commit),
    .o_chrom  (o_cromossomo)
  );

  assign o_chrom_valid = r_valid;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_chrom_loader.sv
// Directed bench for chrom_loader (2x2 grid, one 3-bit selector) with a word-count
// reference model; honours CHROM_LOADER_SEL_CHECK_EN.
module tb_chrom_loader;

  localparam int unsigned NCELL = 4;
  localparam int unsigned NOUT  = 1;
  localparam int unsigned BE    = 3;
  localparam int unsigned BMAT  = NCELL * 16;
  localparam int unsigned CW    = BMAT + BE * NOUT;
  localparam int          TOTAL = NCELL + NOUT;

`ifdef CHROM_LOADER_SEL_CHECK_EN
  localparam bit SelChk = 1'b1;
`else
  localparam bit SelChk = 1'b0;
`endif

  typedef logic [15:0] wv_t [5];

  localparam wv_t WA = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0005};
  localparam wv_t WB = '{16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h0002};
  localparam wv_t WR = '{16'hAAAA, 16'hAAAB, 16'hAAAC, 16'hAAAD, 16'h0006};
  localparam wv_t WD = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0003};
  localparam wv_t WE = '{16'h1357, 16'h2468, 16'h369C, 16'h48AD, 16'h0085};
  localparam wv_t WF = '{16'hF00F, 16'h0FF0, 16'h1001, 16'h0110, 16'h0004};
  localparam wv_t WG = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0007};

  logic          clk;
  logic          rst_n;
  logic          in_abort;
  logic [CW-1:0] o_cromossomo;
  logic          o_chrom_valid;
  logic          o_busy;
`ifdef CHROM_LOADER_SEL_CHECK_EN
  logic          o_err;
`endif

  chrom_loader_if s_if ();

  chrom_loader #(
    .Row      (2),
    .Col      (2),
    .Out      (NOUT),
    .BitsElem (BE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_if          (s_if.slave),
    .i_abort       (in_abort),
    .o_cromossomo  (o_cromossomo),
    .o_chrom_valid (o_chrom_valid),
    .o_busy        (o_busy)
`ifdef CHROM_LOADER_SEL_CHECK_EN
    ,
    .o_err         (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_bad   = 0;
  int n_pulse = 0;

  // Reference model: words taken into the current load, plus what the chromosome holds.
  int            m_n;
  logic [15:0]   m_cell [NCELL];
  logic [BE-1:0] m_sel  [NOUT];
  logic [CW-1:0] m_crom;
  logic          m_valid;
  logic          m_err;
  int            m_commits = 0;

  task automatic model_reset();
    m_n     = 0;
    m_crom  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < NCELL; i++) m_cell[i] = '0;
    for (int i = 0; i < NOUT; i++) m_sel[i] = '0;
  endtask

  task automatic model_update();
    logic [15:0] d;
    d = s_if.s_data;
    m_valid = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_n == TOTAL) begin
      for (int c = 0; c < NCELL; c++) m_crom[16*c +: 16] = m_cell[c];
      for (int k = 0; k < NOUT; k++) m_crom[BMAT + BE*k +: BE] = m_sel[k];
      m_valid = 1'b1;
      m_n     = 0;
      m_commits++;
    end else if (in_abort) begin
      m_n = 0;
    end else if (s_if.s_valid) begin
      if (m_n < NCELL) begin
        m_cell[m_n] = d;
        m_n++;
      end else if (SelChk && (d[15:BE] != '0)) begin
        m_err = 1'b1;
        m_n   = 0;
      end else begin
        m_sel[m_n - NCELL] = d[BE-1:0];
        m_n++;
      end
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk1("s_ready", s_if.s_ready, (m_n != TOTAL));
    chk1("chrom_valid", o_chrom_valid, m_valid);
    chk1("busy", o_busy, (m_n != 0));
    chkw("cromossomo", o_cromossomo, m_crom);
`ifdef CHROM_LOADER_SEL_CHECK_EN
    chk1("err", o_err, m_err);
`endif
    if (o_chrom_valid === 1'b1) n_pulse++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic ab);
    s_if.s_valid = v;
    s_if.s_data  = d;
    in_abort     = ab;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'hDEAD, 1'b0);
  endtask

  task automatic load(input wv_t w);
    for (int i = 0; i < 5; i++) drive(1'b1, w[i], 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst_n        = 1'b0;
    in_abort     = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 16'h0000;
    model_reset();

    @(negedge clk);
    chkw("reset_crom", o_cromossomo, '0);
    chk1("reset_busy", o_busy, 1'b0);
    chk1("reset_valid", o_chrom_valid, 1'b0);
    chk1("reset_ready", s_if.s_ready, 1'b1);
    compare_all();
    rst_n = 1'b1;

    // Back-to-back load.
    load(WA);
    idle(3);
    chkw("load_a", o_cromossomo, {3'b101, 64'h4444_3333_2222_1111});
    chki("pulses_a", n_pulse, 1);

    // Same load with random gaps in s_valid.
    start = m_commits;
    for (int cyc = 0; cyc < 200 && m_commits == start; cyc++) begin
      if (m_n < TOTAL && $urandom_range(0, 1) == 1) drive(1'b1, WA[m_n], 1'b0);
      else drive(1'b0, 16'hBEEF, 1'b0);
    end
    if (m_commits == start) begin
      n_vec++;
      n_bad++;
      $display("FAIL gap_timeout: no commit within 200 cycles");
    end
    idle(1);
    chkw("gap_crom", o_cromossomo, {3'b101, 64'h4444_3333_2222_1111});
    chki("pulses_gap", n_pulse, 2);

    // Word offered during COMMIT waits one cycle, then lands as cell 0.
    load(WB);
    drive(1'b1, 16'h9999, 1'b0);
    drive(1'b1, 16'h9999, 1'b0);
    chkw("load_b", o_cromossomo, {3'b010, 64'h8888_7777_6666_5555});
    chki("pulses_b", n_pulse, 3);
    drive(1'b1, 16'hBBBB, 1'b0);
    chk1("busy_two_words", o_busy, 1'b1);

    // Abort with a coincident word after two accepted words.
    drive(1'b1, 16'hCCCC, 1'b1);
    chk1("abort_busy", o_busy, 1'b0);
    idle(2);
    chkw("abort_crom", o_cromossomo, {3'b010, 64'h8888_7777_6666_5555});
    chki("pulses_abort", n_pulse, 3);

    load(WR);
    idle(2);
    chkw("reload", o_cromossomo, {3'b110, 64'hAAAD_AAAC_AAAB_AAAA});
    chki("pulses_reload", n_pulse, 4);

    // Abort coincident with the final word.
    drive(1'b1, 16'h1234, 1'b0);
    drive(1'b1, 16'h2345, 1'b0);
    drive(1'b1, 16'h3456, 1'b0);
    drive(1'b1, 16'h4567, 1'b0);
    drive(1'b1, 16'h0001, 1'b1);
    idle(2);
    chkw("final_abort_crom", o_cromossomo, {3'b110, 64'hAAAD_AAAC_AAAB_AAAA});
    chki("pulses_final_abort", n_pulse, 4);
    chk1("final_abort_ready", s_if.s_ready, 1'b1);

    // Abort during COMMIT does not stop the commit.
    load(WD);
    drive(1'b0, 16'h0000, 1'b1);
    idle(1);
    chkw("commit_abort", o_cromossomo, {3'b011, 64'h0404_0303_0202_0101});
    chki("pulses_commit_abort", n_pulse, 5);

    // Selector with upper bits set.
    load(WE);
    idle(2);
`ifdef CHROM_LOADER_SEL_CHECK_EN
    chk1("sel_err", o_err, 1'b1);
    chkw("sel_err_crom", o_cromossomo, {3'b011, 64'h0404_0303_0202_0101});
    chki("pulses_sel_err", n_pulse, 5);
`else
    chkw("sel_upper_ignored", o_cromossomo, {3'b101, 64'h48AD_369C_2468_1357});
    chki("pulses_sel_upper", n_pulse, 6);
`endif
    load(WF);
    idle(2);
    chkw("clean_after_sel", o_cromossomo, {3'b100, 64'h0110_1001_0FF0_F00F});
`ifdef CHROM_LOADER_SEL_CHECK_EN
    chk1("err_sticky", o_err, 1'b1);
`endif

    // Asynchronous reset in LOAD_OUT.
    drive(1'b1, 16'h7001, 1'b0);
    drive(1'b1, 16'h7002, 1'b0);
    drive(1'b1, 16'h7003, 1'b0);
    drive(1'b1, 16'h7004, 1'b0);
    chk1("pre_reset_busy", o_busy, 1'b1);
    s_if.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chkw("async_rst_crom", o_cromossomo, '0);
    chk1("async_rst_busy", o_busy, 1'b0);
    chk1("async_rst_valid", o_chrom_valid, 1'b0);
`ifdef CHROM_LOADER_SEL_CHECK_EN
    chk1("async_rst_err", o_err, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    load(WG);
    idle(2);
    chkw("after_reset_load", o_cromossomo, {3'b111, 64'h0004_0003_0002_0001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
